// File: rtl/stream_demux2_pkg.sv
// Shared defaults for the stream_demux2 slice.
package stream_demux2_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/stream_demux2_stage.sv
// stream_stage: one-entry valid/ready register slice with its own transfer counter.
module stream_stage
  import stream_demux2_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] cnt
);

  logic             valid_r;
  logic [WIDTH-1:0] data_r;
  logic [CNT_W-1:0] cnt_r;

  // Occupancy: load wins over drain, so a same-cycle load/drain stays full.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
    end else if (ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Held word; only replaced by a load, which the top allows only when free or draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r <= '0;
    end else if (load) begin
      data_r <= load_data;
    end else begin
      data_r <= data_r;
    end
  end

  // Completed-transfer counter, wraps silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (valid_r && ready) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign valid = valid_r;
  assign data  = data_r;
  assign cnt   = cnt_r;

endmodule

// File: rtl/stream_demux2.sv
// stream_demux2: registered 1-to-2 stream demultiplexer with per-channel transfer counters.
module stream_demux2
  import stream_demux2_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic ready0_s;
  logic ready1_s;
  logic load0_s;
  logic load1_s;

  // Each channel can take a word when empty or draining this cycle; reset blocks acceptance.
  always_comb begin
    ready0_s = !out0_valid || out0_ready;
    ready1_s = !out1_valid || out1_ready;
    if (rst) begin
      in_ready = 1'b0;
    end else if (in_sel) begin
      in_ready = ready1_s;
    end else begin
      in_ready = ready0_s;
    end
    load0_s = in_valid && in_ready && (in_sel == 1'b0);
    load1_s = in_valid && in_ready && (in_sel == 1'b1);
  end

  stream_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ch0 (
    .clk       (clk),
    .rst       (rst),
    .load      (load0_s),
    .load_data (in_data),
    .ready     (out0_ready),
    .valid     (out0_valid),
    .data      (out0_data),
    .cnt       (cnt0)
  );

  stream_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ch1 (
    .clk       (clk),
    .rst       (rst),
    .load      (load1_s),
    .load_data (in_data),
    .ready     (out1_ready),
    .valid     (out1_valid),
    .data      (out1_data),
    .cnt       (cnt1)
  );

endmodule
